sha3_stream_arbiter: RTL and testbench
======================================

# sha3_stream_arbiter

Round-robin arbiter that shares one SHA-3 AXI-Stream hashing datapath between `N_SRC` independent AXI-Stream message sources. It locks a grant for a whole message (first beat to `TLAST`), forwards it to the core's slave port, then holds the grant until the core's digest stream completes. Each digest is routed back with `o_tdest` set to the owning source index. It sits between the system's message producers and the hashing core and guarantees that only one message is ever in flight in the core.

## Interface
Parameters:
- `DATA_WIDTH`, 16, beat width in bits on all streams
- `N_SRC`, 2, number of requesters, legal 2..4
- `TIMEOUT`, 1024, cycles allowed in WAIT_DIGEST without an accepted digest beat; 0 disables

Ports:
- `ACLK` in 1: the single clock
- `ARESETn` in 1: reset, asynchronous, active-low
- `s_tvalid` in N_SRC: per-source valid
- `s_tdata` in N_SRC*DATA_WIDTH: per-source data, source i at bits [i*DW +: DW]
- `s_tlast` in N_SRC: per-source end of message
- `s_tuser` in N_SRC*2: per-source SHA mode select
- `s_tready` out N_SRC: per-source ready
- `m_tvalid`, `m_tdata` (DW), `m_tlast`, `m_tuser` (2) out: message stream to core
- `m_tready` in 1: core ready
- `d_tvalid`, `d_tdata` (DW), `d_tlast` in: digest stream from core
- `d_tready` out 1
- `o_tvalid`, `o_tdata` (DW), `o_tlast` out; `o_tdest` out 2: digest to requesters, tagged with source index
- `o_tready` in 1
- `grant` out 2: current owner index
- `busy` out 1: high in any state other than IDLE
- `err_timeout` out 1: one-cycle pulse on digest timeout

## Operation
- States: IDLE, FORWARD, WAIT_DIGEST.
- IDLE: if any `s_tvalid` is high, pick the first requester at or after `rr_ptr`, scanning upward with wrap. Register it into `grant` and go to FORWARD. All `s_tready`, `m_tvalid`, and `d_tready` are 0.
- FORWARD: combinational pass-through from source `grant`.
  - `m_tvalid=s_tvalid[g]`, `m_tdata/m_tlast/m_tuser` come from slice g, `s_tready[g]=m_tready`.
  - All other `s_tready` are 0.
  - When a beat is accepted with `s_tlast[g]=1` (`m_tvalid&m_tready&m_tlast`), go to WAIT_DIGEST.
- WAIT_DIGEST: `o_tvalid=d_tvalid`, `o_tdata=d_tdata`, `o_tlast=d_tlast`, `o_tdest=grant`, `d_tready=o_tready`.
  - When a beat is accepted with `d_tlast=1`, go to IDLE and set `rr_ptr=(grant+1) mod N_SRC`.
- Outside WAIT_DIGEST: `d_tready=0`, `o_tvalid=0`. The core is back-pressured, and no digest beats are dropped.
- Timeout counter:
  - Clears on entry to WAIT_DIGEST and on every accepted digest beat. Increments otherwise while in WAIT_DIGEST.
  - When it equals `TIMEOUT` (nonzero): pulse `err_timeout` for 1 cycle, go to IDLE, advance `rr_ptr` as for normal completion.
- Lone `s_tvalid` from a non-granted source stays pending. It is never acknowledged.
- Reset (any time, including mid-message): state IDLE, `rr_ptr=0`, `grant=0`, counter 0. All outputs return to reset values immediately. The partial message is abandoned; sources must restart it.

## Timing
- Reset values: all `s_tready`, `m_tvalid`, `m_tlast`, `d_tready`, `o_tvalid`, `o_tlast`, `busy`, `err_timeout` are 0. `grant`, `o_tdest` are 0. Data outputs are 0.
- Grant latency: `s_tvalid` seen in IDLE at cycle n means FORWARD at n+1, and the first beat can transfer at n+1.
- Data paths in FORWARD/WAIT_DIGEST are zero-latency, with no registers in the data path.
- Last message beat accepted at cycle n: WAIT_DIGEST from n+1.
- Final digest beat accepted at n: IDLE at n+1, and a new grant can be registered at n+1, so FORWARD is at n+2.
- Minimum inter-message gap is 1 idle cycle.
- Single-beat message (first beat has `s_tlast=1`): FORWARD lasts exactly one transferring cycle.
- Timeout: with no digest beat accepted, `err_timeout` goes high in cycle n+`TIMEOUT` after entry at cycle n.

## Test plan
- Reset mid-FORWARD (source 1, 3 of 5 beats sent) -> next cycle all outputs 0, `busy=0`; after release, source 0 and source 1 both valid -> source 0 granted first.
- Sources 0 and 1 continuously valid, 4-beat messages, core digest 2 beats each -> grants alternate 0,1,0,1. `o_tdest` matches each grant. `s_tready` of the non-owner stays 0 throughout.
- Source 1 only, single-beat message, `m_tready` held 0 for 3 cycles -> beat held stable on `m_*`. Transfer happens when `m_tready` rises, then WAIT_DIGEST.
- Digest with `o_tready` toggling 1,0,1,0 over 4 beats -> `d_tready` mirrors `o_tready`, exactly 4 beats transferred, and `o_tlast` appears only on the 4th.
- `TIMEOUT=8`, core never returns a digest -> `err_timeout` high for one cycle 8 cycles after WAIT_DIGEST entry. Next grant goes to `(grant+1) mod N_SRC`.
- `N_SRC=4`, only sources 3 and 1 valid, `rr_ptr=2` -> source 3 granted, then source 1 (wrap through 0).

Source files
------------

// File: rtl/sha3_stream_arbiter_if.sv
// Stream bundle between the message sources, the SHA-3 core and the digest
// consumers. The arbiter uses the slave view; the producers/core/consumers
// side (or a bench) uses the master view.
interface sha3_stream_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_SRC      = 2
);
  // per-source message streams
  logic [N_SRC-1:0]            s_tvalid;
  logic [N_SRC*DATA_WIDTH-1:0] s_tdata;
  logic [N_SRC-1:0]            s_tlast;
  logic [N_SRC*2-1:0]          s_tuser;
  logic [N_SRC-1:0]            s_tready;
  // message stream to the core
  logic                        m_tvalid;
  logic [DATA_WIDTH-1:0]       m_tdata;
  logic                        m_tlast;
  logic [1:0]                  m_tuser;
  logic                        m_tready;
  // digest stream from the core
  logic                        d_tvalid;
  logic [DATA_WIDTH-1:0]       d_tdata;
  logic                        d_tlast;
  logic                        d_tready;
  // tagged digest stream back to the requesters
  logic                        o_tvalid;
  logic [DATA_WIDTH-1:0]       o_tdata;
  logic                        o_tlast;
  logic [1:0]                  o_tdest;
  logic                        o_tready;
  // status
  logic [1:0]                  grant;
  logic                        busy;
  logic                        err_timeout;

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, s_tuser,
    output s_tready,
    output m_tvalid, m_tdata, m_tlast, m_tuser,
    input  m_tready,
    input  d_tvalid, d_tdata, d_tlast,
    output d_tready,
    output o_tvalid, o_tdata, o_tlast, o_tdest,
    input  o_tready,
    output grant, busy, err_timeout
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast, s_tuser,
    input  s_tready,
    input  m_tvalid, m_tdata, m_tlast, m_tuser,
    output m_tready,
    output d_tvalid, d_tdata, d_tlast,
    input  d_tready,
    input  o_tvalid, o_tdata, o_tlast, o_tdest,
    output o_tready,
    input  grant, busy, err_timeout
  );
endinterface

// File: rtl/sha3_stream_arbiter.sv
// Round-robin arbiter sharing one SHA-3 stream core among N_SRC sources.
// A grant is held from the first message beat until the core's final digest
// beat (or a digest timeout), so exactly one message is ever in the core.
// Data paths are pure combinational muxes; only control state is registered.
module sha3_stream_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int N_SRC      = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  sha3_stream_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, FORWARD, WAIT_DIGEST} state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [1:0]      pick;
  logic            pick_vld;
  logic [1:0]      next_ptr;
  logic            timeout_hit;

  // Sources padded to 4 slots so the grant index can select any of them
  // without width games; unused slots read as idle.
  logic [3:0]                 vld4, lst4;
  logic [3:0][DATA_WIDTH-1:0] dat4;
  logic [3:0][1:0]            usr4;

  for (genvar i = 0; i < 4; i++) begin : g_pad
    if (i < N_SRC) begin : g_src
      assign vld4[i] = bus.s_tvalid[i];
      assign lst4[i] = bus.s_tlast[i];
      assign dat4[i] = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign usr4[i] = bus.s_tuser[2*i +: 2];
      // only the owner sees the core's ready, and only while forwarding
      assign bus.s_tready[i] = (state_q == FORWARD) && (grant_q == 2'(i)) && bus.m_tready;
    end else begin : g_nil
      assign vld4[i] = 1'b0;
      assign lst4[i] = 1'b0;
      assign dat4[i] = '0;
      assign usr4[i] = '0;
    end
  end

  assign next_ptr    = (grant_q == 2'(N_SRC - 1)) ? 2'd0 : grant_q + 2'd1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
  assign bus.grant   = grant_q;
  assign bus.busy    = (state_q != IDLE);

  // Round-robin pick: first valid source at or after rr_ptr, with wrap.
  // Scanning from the far end lets the nearest hit overwrite the others.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (vld4[2'(idx)]) begin
        pick     = 2'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and stream muxing; everything idles at zero outside its phase.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    bus.m_tvalid    = 1'b0;
    bus.m_tdata     = '0;
    bus.m_tlast     = 1'b0;
    bus.m_tuser     = '0;
    bus.d_tready    = 1'b0;
    bus.o_tvalid    = 1'b0;
    bus.o_tdata     = '0;
    bus.o_tlast     = 1'b0;
    bus.o_tdest     = '0;
    bus.err_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = FORWARD;
        end
      end
      FORWARD: begin
        bus.m_tvalid = vld4[grant_q];
        bus.m_tdata  = dat4[grant_q];
        bus.m_tlast  = lst4[grant_q];
        bus.m_tuser  = usr4[grant_q];
        if (vld4[grant_q] && bus.m_tready && lst4[grant_q]) begin
          state_d = WAIT_DIGEST;
          cnt_d   = '0;
        end
      end
      WAIT_DIGEST: begin
        bus.o_tvalid = bus.d_tvalid;
        bus.o_tdata  = bus.d_tdata;
        bus.o_tlast  = bus.d_tlast;
        bus.o_tdest  = grant_q;
        bus.d_tready = bus.o_tready;
        if (timeout_hit) begin
          // core went silent: give up on this message, move the pointer on
          bus.err_timeout = 1'b1;
          state_d         = IDLE;
          rr_ptr_d        = next_ptr;
        end else if (bus.d_tvalid && bus.o_tready) begin
          cnt_d = '0;
          if (bus.d_tlast) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset abandons any message in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_sha3_stream_arbiter.sv
// Bench for sha3_stream_arbiter (4 sources, timeout 8). A message-level
// reference model (owner / phase / silent-cycle count) predicts every
// output each cycle; directed steps then random traffic drive it.
module tb_sha3_stream_arbiter;
  localparam int DW = 16;
  localparam int NS = 4;
  localparam int TO = 8;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  sha3_stream_arbiter_if #(.DATA_WIDTH(DW), .N_SRC(NS)) bus ();

  sha3_stream_arbiter #(.DATA_WIDTH(DW), .N_SRC(NS), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus)
  );

  int vectors = 0;
  int errs    = 0;

  // reference model state
  int owner;       // -1 when no message holds the core
  bit in_digest;   // owner's message fully sent, waiting for digest
  int ptr;         // where the next scan starts
  int gnt;         // last granted source
  int quiet;       // cycles waiting without an accepted digest beat
  int sent[NS];    // accepted beats of the current message per source
  int dsent;       // accepted digest beats of the current digest
  int done_cnt;
  int grants[$];

  // observation counters
  int cyc = 0, dig_x = 0, acc_last = 0, err_n = 0, err_at = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; in_digest = 0; ptr = 0; gnt = 0; quiet = 0; dsent = 0;
    foreach (sent[i]) sent[i] = 0;
  endtask

  task automatic check_all();
    logic [NS-1:0] e_rdy;
    logic e_mv, e_ml, e_ov, e_ol, e_dr, e_err;
    logic [DW-1:0] e_md, e_od;
    logic [1:0] e_mu, e_dst;
    e_rdy = '0; e_mv = 0; e_ml = 0; e_md = '0; e_mu = '0;
    e_ov = 0; e_ol = 0; e_od = '0; e_dr = 0; e_dst = '0; e_err = 0;
    if (owner >= 0 && !in_digest) begin
      e_mv = bus.s_tvalid[owner];
      e_md = bus.s_tdata[owner*DW +: DW];
      e_ml = bus.s_tlast[owner];
      e_mu = bus.s_tuser[2*owner +: 2];
      e_rdy[owner] = bus.m_tready;
    end
    if (owner >= 0 && in_digest) begin
      e_ov = bus.d_tvalid; e_od = bus.d_tdata; e_ol = bus.d_tlast;
      e_dr = bus.o_tready; e_dst = 2'(owner); e_err = (quiet == TO);
    end
    chk("s_tready", 32'(bus.s_tready), 32'(e_rdy));
    chk("m_tvalid", 32'(bus.m_tvalid), 32'(e_mv));
    chk("m_tdata",  32'(bus.m_tdata),  32'(e_md));
    chk("m_tlast",  32'(bus.m_tlast),  32'(e_ml));
    chk("m_tuser",  32'(bus.m_tuser),  32'(e_mu));
    chk("d_tready", 32'(bus.d_tready), 32'(e_dr));
    chk("o_tvalid", 32'(bus.o_tvalid), 32'(e_ov));
    chk("o_tdata",  32'(bus.o_tdata),  32'(e_od));
    chk("o_tlast",  32'(bus.o_tlast),  32'(e_ol));
    chk("o_tdest",  32'(bus.o_tdest),  32'(e_dst));
    chk("grant",    32'(bus.grant),    32'(gnt));
    chk("busy",     32'(bus.busy),     32'(owner >= 0));
    chk("err_timeout", 32'(bus.err_timeout), 32'(e_err));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    if (owner < 0) begin
      for (int k = 0; k < NS; k++) begin
        int c;
        c = (ptr + k) % NS;
        if (bus.s_tvalid[c]) begin
          owner = c; gnt = c; in_digest = 0; grants.push_back(c);
          break;
        end
      end
    end else if (!in_digest) begin
      if (bus.s_tvalid[owner] && bus.m_tready) begin
        if (bus.s_tlast[owner]) begin
          sent[owner] = 0; in_digest = 1; quiet = 0;
        end else sent[owner]++;
      end
    end else begin
      if (quiet == TO) begin
        ptr = (owner + 1) % NS; owner = -1; in_digest = 0; dsent = 0;
      end else if (bus.d_tvalid && bus.o_tready) begin
        quiet = 0;
        if (bus.d_tlast) begin
          ptr = (owner + 1) % NS; owner = -1; in_digest = 0; dsent = 0; done_cnt++;
        end else dsent++;
      end else quiet++;
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
    check_all();
    if (bus.d_tvalid && bus.d_tready) dig_x++;
    if (bus.o_tvalid && bus.o_tready && bus.o_tlast) acc_last++;
    if (bus.err_timeout) begin err_n++; err_at = cyc; end
    model_step();
    cyc++;
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_auto(input logic [NS-1:0] mask, input int len, input int dlen, input bit rnd);
    for (int i = 0; i < NS; i++) begin
      bus.s_tvalid[i] = mask[i] && (!rnd || $urandom_range(0, 3) != 0);
      bus.s_tlast[i]  = (sent[i] >= len - 1);
      bus.s_tdata[i*DW +: DW] = DW'($urandom);
      bus.s_tuser[2*i +: 2]   = 2'($urandom);
    end
    bus.m_tready = !rnd || $urandom_range(0, 3) != 0;
    bus.d_tvalid = rnd ? ($urandom_range(0, 2) != 0) : (owner >= 0 && in_digest);
    bus.d_tlast  = (dsent >= dlen - 1);
    bus.d_tdata  = DW'($urandom);
    bus.o_tready = !rnd || $urandom_range(0, 3) != 0;
  endtask

  task automatic run_msgs(input logic [NS-1:0] mask, input int len, input int dlen,
                          input int n, input string tag);
    int target;
    target = done_cnt + n;
    for (int c = 0; c < 400 && done_cnt < target; c++) begin
      drive_auto(mask, len, dlen, 0);
      tick();
    end
    chk(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] held;
    int t0;
    bus.s_tvalid = '0; bus.s_tdata = '0; bus.s_tlast = '0; bus.s_tuser = '0;
    bus.m_tready = 0; bus.d_tvalid = 0; bus.d_tdata = '0; bus.d_tlast = 0; bus.o_tready = 0;
    model_reset();
    done_cnt = 0;

    // reset state
    #2;
    check_all();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // reset in the middle of a 5-beat message from source 1
    for (int c = 0; c < 40 && !(owner == 1 && sent[1] == 3); c++) begin
      drive_auto(4'b0010, 5, 2, 0);
      tick();
    end
    chk("mid_msg_reached", 32'(sent[1]), 32'd3);
    ARESETn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge ACLK);
    check_all();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // two sources always valid, 4-beat messages, 2-beat digests
    grants.delete();
    run_msgs(4'b0011, 4, 2, 4, "alt_done");
    chk("alt_n",  32'(grants.size()), 32'd4);
    chk("alt_g0", 32'(grants[0]), 32'd0);
    chk("alt_g1", 32'(grants[1]), 32'd1);
    chk("alt_g2", 32'(grants[2]), 32'd0);
    chk("alt_g3", 32'(grants[3]), 32'd1);

    // source 1 single beat, core stalls 3 cycles
    drive_auto(4'b0010, 1, 4, 0);
    bus.m_tready = 0;
    held = bus.s_tdata[1*DW +: DW];
    tick();
    chk("stall_grant", 32'(bus.grant), 32'd1);
    repeat (3) tick();
    chk("stall_mvalid", 32'(bus.m_tvalid), 32'd1);
    chk("stall_mdata",  32'(bus.m_tdata), 32'(held));
    chk("stall_mlast",  32'(bus.m_tlast), 32'd1);
    bus.m_tready = 1;
    tick();
    chk("stall_to_wait", 32'({bus.busy, bus.m_tvalid}), 32'b10);

    // 4-beat digest with o_tready toggling 1,0,1,0
    dig_x = 0; acc_last = 0;
    bus.s_tvalid = '0;
    for (int c = 0; c < 16 && owner >= 0; c++) begin
      bus.d_tvalid = 1;
      bus.d_tdata  = DW'($urandom);
      bus.d_tlast  = (dsent == 3);
      bus.o_tready = (c % 2 == 0);
      tick();
    end
    chk("dig_beats", 32'(dig_x), 32'd4);
    chk("dig_last",  32'(acc_last), 32'd1);
    chk("dig_idle",  32'(bus.busy), 32'd0);

    // source 3 single beat, core never answers
    drive_auto(4'b1000, 1, 2, 0);
    tick();
    chk("to_grant", 32'(bus.grant), 32'd3);
    tick();
    bus.s_tvalid = '0; bus.d_tvalid = 0;
    err_n = 0; err_at = -1; t0 = cyc;
    repeat (12) tick();
    chk("to_pulses", 32'(err_n), 32'd1);
    chk("to_delay",  32'(err_at - t0), 32'(TO));
    grants.delete();
    run_msgs(4'b1001, 2, 1, 1, "to_next_done");
    chk("to_next_grant", 32'(grants[0]), 32'd0);

    // pointer to 2, then sources 3 and 1 contend: 3 first, wrap to 1
    run_msgs(4'b0010, 1, 1, 1, "ptr2_done");
    grants.delete();
    run_msgs(4'b1010, 2, 2, 2, "wrap_done");
    chk("wrap_g0", 32'(grants[0]), 32'd3);
    chk("wrap_g1", 32'(grants[1]), 32'd1);

    // random traffic
    for (int c = 0; c < 800; c++) begin
      drive_auto(NS'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
